cachepool_l2_rd_responder: RTL and testbench

AXI4 read-channel responder for one L2/DRAM channel. It sits at the memory end of the cluster-to-L2 path and serves bursts issued by the cache controllers and the Snitch port. The incoming AR address is in the scrambled, interleaved layout; the block applies the inverse interleave permutation, then issues single-cycle SRAM reads. R beats return in order through a credit-controlled output buffer, so R backpressure never drops data.

---
 rtl/cachepool_l2_rd_responder.sv | 167 ++++++++++++++++
 tb/tb_cachepool_l2_rd_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cachepool_l2_rd_responder.sv
// AXI4 read responder for one L2 channel: un-scrambles AR addresses, issues
// single-cycle SRAM reads and returns R beats in order through a credit buffer.
module cachepool_l2_rd_responder #(
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 128,
    parameter int IdWidth        = 8,
    parameter int ConstantBits   = 10,
    parameter int ScrambleBits   = 2,
    parameter int SizeOffsetBits = 28,
    parameter int BufDepth       = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    input  logic [2:0]           ar_size_i,
    input  logic [1:0]           ar_burst_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);
    localparam int InterBits = SizeOffsetBits - ConstantBits;
    localparam int UpperBits = AddrWidth - ScrambleBits - SizeOffsetBits;
    localparam int OffBits   = $clog2(DataWidth / 8);
    localparam int PtrW      = $clog2(BufDepth);
    localparam int CntW      = $clog2(BufDepth + 1);
    localparam logic [CntW:0] Depth   = (CntW + 1)'(BufDepth);
    localparam logic [2:0]    MaxSize = 3'(OffBits);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_ERR} state_e;

    state_e                 r_state, w_state_nxt;
    logic                   r_live;
    logic [IdWidth-1:0]     r_id;
    logic [AddrWidth-1:0]   r_addr;
    logic [7:0]             r_len, r_beat;
    logic [2:0]             r_size;
    logic                   r_fixed;
    logic                   r_infl, r_infl_last, r_infl_err;
    logic [IdWidth-1:0]     r_infl_id;
    logic [CntW-1:0]        r_occ;
    logic [PtrW-1:0]        r_wptr, r_rptr;
    logic [IdWidth-1:0]     r_buf_id   [BufDepth];
    logic [DataWidth-1:0]   r_buf_data [BufDepth];
    logic [1:0]             r_buf_resp [BufDepth];
    logic                   r_buf_last [BufDepth];

    logic [AddrWidth-1:0]   w_revert;
    logic                   w_ar_ready, w_ar_hs, w_bad, w_issue, w_last;
    logic [CntW:0]          w_used;
    logic                   w_credit, w_head_buf, w_bypass, w_push, w_pop_buf;
    logic [DataWidth-1:0]   w_in_data;
    logic [1:0]             w_in_resp;

    assign w_revert = {ar_addr_i[AddrWidth-1 -: UpperBits],
                       ar_addr_i[ConstantBits+InterBits-1:ConstantBits],
                       ar_addr_i[SizeOffsetBits+ScrambleBits-1:SizeOffsetBits],
                       ar_addr_i[ConstantBits-1:0]};

    assign w_bad   = ar_burst_i[1] | (ar_size_i > MaxSize);
    assign w_last  = (r_beat == r_len);
    assign w_ar_hs = ar_valid_i & w_ar_ready;

    // A pop this cycle frees a slot, keeping back-to-back issue at full rate.
    assign w_used   = {1'b0, r_occ} + {{CntW{1'b0}}, r_infl};
    assign w_credit = (w_used < Depth) | (r_valid_o & r_ready_i);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_ar_ready  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ar_ready = r_live;
                if (ar_valid_i && r_live)
                    w_state_nxt = w_bad ? S_ERR : S_BURST;
            end
            S_BURST, S_ERR: begin
                w_issue = w_credit;
                if (w_credit && w_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ar_ready_o = w_ar_ready;
    assign mem_req_o  = w_issue & (r_state == S_BURST);
    assign mem_addr_o = mem_req_o ? {r_addr[AddrWidth-1:OffBits], {OffBits{1'b0}}} : '0;

    // Returning read bypasses the buffer straight to R when the buffer is empty.
    assign w_head_buf = (r_occ != '0);
    assign w_in_data  = r_infl_err ? '0 : mem_rdata_i;
    assign w_in_resp  = r_infl_err ? 2'b10 : 2'b00;
    assign w_bypass   = r_infl & ~w_head_buf & r_ready_i;
    assign w_push     = r_infl & ~w_bypass;
    assign w_pop_buf  = w_head_buf & r_ready_i;

    assign r_valid_o = w_head_buf | r_infl;
    assign r_id_o    = w_head_buf ? r_buf_id[r_rptr]   : (r_infl ? r_infl_id   : '0);
    assign r_data_o  = w_head_buf ? r_buf_data[r_rptr] : (r_infl ? w_in_data   : '0);
    assign r_resp_o  = w_head_buf ? r_buf_resp[r_rptr] : (r_infl ? w_in_resp   : 2'b00);
    assign r_last_o  = w_head_buf ? r_buf_last[r_rptr] : (r_infl & r_infl_last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_live      <= 1'b0;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_fixed     <= 1'b0;
            r_beat      <= '0;
            r_infl      <= 1'b0;
            r_infl_id   <= '0;
            r_infl_last <= 1'b0;
            r_infl_err  <= 1'b0;
            r_occ       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_live      <= 1'b1;
            r_infl      <= w_issue;
            r_infl_id   <= r_id;
            r_infl_last <= w_last;
            r_infl_err  <= (r_state == S_ERR);
            if (w_ar_hs) begin
                r_id    <= ar_id_i;
                r_addr  <= w_revert;
                r_len   <= ar_len_i;
                r_size  <= ar_size_i;
                r_fixed <= ~ar_burst_i[0];
                r_beat  <= '0;
            end else if (w_issue) begin
                r_beat <= r_beat + 8'd1;
                if (!r_fixed)
                    r_addr <= r_addr + (AddrWidth'(1) << r_size);
            end
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop_buf)
                r_rptr <= r_rptr + 1'b1;
            r_occ <= r_occ + CntW'(w_push) - CntW'(w_pop_buf);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_buf_id[r_wptr]   <= r_infl_id;
            r_buf_data[r_wptr] <= w_in_data;
            r_buf_resp[r_wptr] <= w_in_resp;
            r_buf_last[r_wptr] <= r_infl_last;
        end
    end

endmodule

// File: tb/tb_cachepool_l2_rd_responder.sv
// Scoreboard bench for cachepool_l2_rd_responder with a 1-cycle SRAM model.
module tb_cachepool_l2_rd_responder;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ar_valid = 1'b0, ar_ready;
    logic [7:0]   ar_id = '0;
    logic [31:0]  ar_addr = '0;
    logic [7:0]   ar_len = '0;
    logic [2:0]   ar_size = '0;
    logic [1:0]   ar_burst = '0;
    logic         r_valid, r_ready = 1'b0;
    logic [7:0]   r_id;
    logic [127:0] r_data;
    logic [1:0]   r_resp;
    logic         r_last;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [127:0] mem_rdata = '0;

    typedef struct packed {
        logic [7:0]   id;
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] addr_q[$];
    int n_chk = 0, n_err = 0, cyc = 0, n_req = 0;
    int t_req1 = -1, t_reql = -1, t_rv1 = -1;

    always #5 clk = ~clk;

    cachepool_l2_rd_responder dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .ar_size_i(ar_size), .ar_burst_i(ar_burst),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
    );

    function automatic logic [127:0] mem_f(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
    endfunction

    always @(posedge clk)
        mem_rdata <= mem_req ? mem_f(mem_addr) : '0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (mem_req) begin
                n_req++;
                if (t_req1 < 0) t_req1 = cyc;
                t_reql = cyc;
                if (addr_q.size() == 0) chk("mem_req_spurious", 1, 0);
                else chk("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (r_valid && t_rv1 < 0) t_rv1 = cyc;
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0) chk("r_spurious", 1, 0);
                else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("r_id", r_id, e.id);
                    chk("r_data", r_data, e.data);
                    chk("r_resp", r_resp, e.resp);
                    chk("r_last", r_last, e.last);
                end
            end
        end
    end

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [31:0] base,
                           input bit err);
        bit hs = 0;
        for (int i = 0; i <= int'(len); i++) begin
            beat_t b;
            logic [31:0] a;
            a = (burst == 2'b01) ? base + (32'(i) << size) : base;
            if (!err) addr_q.push_back(a);
            b.id   = id;
            b.data = err ? '0 : mem_f(a);
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
        ar_id = id; ar_addr = addr; ar_len = len;
        ar_size = size; ar_burst = burst; ar_valid = 1'b1;
        for (int k = 0; k < 100 && !hs; k++) begin
            @(negedge clk);
            if (ar_ready) begin
                @(posedge clk);
                #1;
                hs = 1;
            end
        end
        ar_valid = 1'b0;
        if (!hs) chk("ar_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        bool_loop: for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && addr_q.size() == 0 && !r_valid)
                break;
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0 || addr_q.size() != 0)
            chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r_valid", r_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_r_data", r_data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ar_ready", ar_ready, 1);

        r_ready = 1'b1;
        t_req1 = -1; t_rv1 = -1;
        send_ar(8'd5, 32'h8000_0400, 8'd3, 3'd4, 2'b01, 32'h8000_1000, 0);
        drain(50);
        chk("r_latency", t_rv1 - t_req1, 1);
        chk("req_consecutive", t_reql - t_req1, 3);

        send_ar(8'd7, 32'h9000_0000, 8'd1, 3'd4, 2'b00, 32'h8000_0400, 0);
        drain(50);

        r_ready = 1'b0;
        n0 = n_req;
        send_ar(8'd3, 32'h8000_0000, 8'd7, 3'd4, 2'b01, 32'h8000_0000, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_req_le2", (n_req - n0) <= 2, 1);
        chk("stall_r_valid", r_valid, 1);
        chk("stall_head", r_data, exp_q[0].data);
        r_ready = 1'b1;
        drain(80);

        n0 = n_req;
        send_ar(8'd9, 32'h8000_0400, 8'd2, 3'd4, 2'b10, 32'h0, 1);
        drain(50);
        send_ar(8'd4, 32'h8000_0400, 8'd0, 3'd5, 2'b01, 32'h0, 1);
        drain(50);
        chk("err_no_req", n_req - n0, 0);

        fork
            begin
                send_ar(8'd1, 32'h8000_0000, 8'd0, 3'd4, 2'b01, 32'h8000_0000, 0);
                send_ar(8'd2, 32'h8000_0800, 8'd1, 3'd4, 2'b01, 32'h8000_2000, 0);
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    r_ready = 1'($urandom_range(0, 1));
                end
                r_ready = 1'b1;
            end
        join
        drain(80);

        send_ar(8'd6, 32'h8000_0000, 8'd255, 3'd4, 2'b01, 32'h8000_0000, 0);
        drain(800);

        r_ready = 1'b0;
        send_ar(8'd8, 32'h8000_0000, 8'd7, 3'd4, 2'b01, 32'h8000_0000, 0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_r_valid", r_valid, 0);
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_ar_ready", ar_ready, 0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_ar_ready", ar_ready, 1);
        r_ready = 1'b1;
        send_ar(8'd10, 32'h8000_0400, 8'd0, 3'd4, 2'b01, 32'h8000_1000, 0);
        drain(50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
